// File: rtl/rxdata_if.sv
// Serial input and decoded-word outputs of the rxdata receiver.
// The slave side is the receiver itself; the master side is whoever drives the line and consumes words.
interface rxdata_if;
  logic        i_uart_rx;
  logic        o_stb;
  logic [31:0] o_data;
  logic        o_err;

  modport master (output i_uart_rx, input o_stb, o_data, o_err);
  modport slave  (input i_uart_rx, output o_stb, o_data, o_err);
endinterface

// File: rtl/rxdata.sv
// 8N1 UART receiver plus a line parser that turns "0x" + 8 hex digits + CR LF into one 32-bit word.
// Malformed characters and bad stop bits produce a one-cycle error pulse instead of a word.
module rxdata #(
  parameter int CLOCKS_PER_BAUD = 868
) (
  input logic     i_clk,
  input logic     i_reset,
  rxdata_if.slave bus
);

  localparam logic [23:0] HALF_M1 = 24'(CLOCKS_PER_BAUD / 2 - 1);
  localparam logic [23:0] FULL_M1 = 24'(CLOCKS_PER_BAUD - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {P_ZERO, P_X, P_DIG, P_CR, P_LF} p_state_t;

  logic        rx_meta, rx;
  rx_state_t   rx_state, rx_state_next;
  logic [23:0] baud_cnt, baud_cnt_next;
  logic [2:0]  bit_cnt, bit_cnt_next;
  logic [7:0]  shift, shift_next;
  logic        byte_stb, byte_stb_next;
  logic        frame_err, frame_err_next;

  p_state_t    p_state, p_state_next;
  logic [31:0] acc, acc_next;
  logic [2:0]  dig_cnt, dig_cnt_next;
  logic [31:0] data_r, data_next;
  logic        stb_r, stb_next;
  logic        err_r, err_next;
  logic [4:0]  hex;

  assign bus.o_stb  = stb_r;
  assign bus.o_data = data_r;
  assign bus.o_err  = err_r;

  // Returns {valid, nibble} for an ASCII hex digit of either case.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    logic [4:0] r;
    r = 5'b0;
    if (c >= 8'h30 && c <= 8'h39)      r = {1'b1, 4'(c - 8'h30)};
    else if (c >= 8'h61 && c <= 8'h66) r = {1'b1, 4'(c - 8'h57)};
    else if (c >= 8'h41 && c <= 8'h46) r = {1'b1, 4'(c - 8'h37)};
    return r;
  endfunction

  // The serial line is asynchronous; both flops idle high so reset never looks like a start bit.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx      <= 1'b1;
    end else begin
      rx_meta <= bus.i_uart_rx;
      rx      <= rx_meta;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_state  <= RX_IDLE;
      baud_cnt  <= 24'd0;
      bit_cnt   <= 3'd0;
      shift     <= 8'd0;
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_state  <= rx_state_next;
      baud_cnt  <= baud_cnt_next;
      bit_cnt   <= bit_cnt_next;
      shift     <= shift_next;
      byte_stb  <= byte_stb_next;
      frame_err <= frame_err_next;
    end
  end

  // Every bit is sampled when the counter reaches zero; the first load of half a baud centres the samples.
  always_comb begin
    rx_state_next  = rx_state;
    baud_cnt_next  = baud_cnt;
    bit_cnt_next   = bit_cnt;
    shift_next     = shift;
    byte_stb_next  = 1'b0;
    frame_err_next = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rx) begin
          baud_cnt_next = HALF_M1;
          rx_state_next = RX_START;
        end
      end
      RX_START: begin
        if (baud_cnt != 24'd0) begin
          baud_cnt_next = baud_cnt - 24'd1;
        end else if (rx) begin
          rx_state_next = RX_IDLE;
        end else begin
          baud_cnt_next = FULL_M1;
          bit_cnt_next  = 3'd0;
          rx_state_next = RX_DATA;
        end
      end
      RX_DATA: begin
        if (baud_cnt != 24'd0) begin
          baud_cnt_next = baud_cnt - 24'd1;
        end else begin
          shift_next    = {rx, shift[7:1]};
          baud_cnt_next = FULL_M1;
          bit_cnt_next  = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) rx_state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (baud_cnt != 24'd0) begin
          baud_cnt_next = baud_cnt - 24'd1;
        end else begin
          byte_stb_next  = rx;
          frame_err_next = !rx;
          rx_state_next  = RX_IDLE;
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      p_state <= P_ZERO;
      acc     <= 32'd0;
      dig_cnt <= 3'd0;
      data_r  <= 32'd0;
      stb_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      p_state <= p_state_next;
      acc     <= acc_next;
      dig_cnt <= dig_cnt_next;
      data_r  <= data_next;
      stb_r   <= stb_next;
      err_r   <= err_next;
    end
  end

  // A bad byte that happens to be '0' can still open a new line, so it resynchronises straight to P_X.
  always_comb begin
    p_state_next = p_state;
    acc_next     = acc;
    dig_cnt_next = dig_cnt;
    data_next    = data_r;
    stb_next     = 1'b0;
    err_next     = 1'b0;
    hex          = hex_decode(shift);
    if (frame_err) begin
      err_next     = 1'b1;
      p_state_next = P_ZERO;
    end else if (byte_stb) begin
      case (p_state)
        P_ZERO: if (shift == 8'h30) p_state_next = P_X;
        P_X: begin
          if (shift == 8'h78) begin
            acc_next     = 32'd0;
            dig_cnt_next = 3'd0;
            p_state_next = P_DIG;
          end else begin
            err_next     = 1'b1;
            p_state_next = (shift == 8'h30) ? P_X : P_ZERO;
          end
        end
        P_DIG: begin
          if (hex[4]) begin
            acc_next     = {acc[27:0], hex[3:0]};
            dig_cnt_next = dig_cnt + 3'd1;
            if (dig_cnt == 3'd7) p_state_next = P_CR;
          end else begin
            err_next     = 1'b1;
            p_state_next = (shift == 8'h30) ? P_X : P_ZERO;
          end
        end
        P_CR: begin
          if (shift == 8'h0D) begin
            p_state_next = P_LF;
          end else begin
            err_next     = 1'b1;
            p_state_next = (shift == 8'h30) ? P_X : P_ZERO;
          end
        end
        P_LF: begin
          if (shift == 8'h0A) begin
            data_next    = acc;
            stb_next     = 1'b1;
            p_state_next = P_ZERO;
          end else begin
            err_next     = 1'b1;
            p_state_next = (shift == 8'h30) ? P_X : P_ZERO;
          end
        end
        default: p_state_next = P_ZERO;
      endcase
    end
  end

endmodule

// File: tb/tb_rxdata.sv
// Self-checking bench for rxdata: drives 8N1 hex lines, queues the expected words and compares them as they emerge.
module tb_rxdata;
  localparam int CPB = 16;

  logic i_clk = 1'b0;
  logic i_reset;
  int   checks_total = 0;
  int   checks_passed = 0;
  int   stb_seen = 0;
  int   err_seen = 0;
  int   errs_expected = 0;
  int   stbs_expected = 0;
  logic monitor_on = 1'b0;
  logic prev_stb = 1'b0;
  logic prev_err = 1'b0;
  logic [31:0] held = 32'd0;
  logic [31:0] exp_q[$];

  rxdata_if bus();

  rxdata #(.CLOCKS_PER_BAUD(CPB)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus.slave)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    else
      checks_passed++;
  endtask

  // Watches the outputs away from the clock edge and pops the scoreboard on every word strobe.
  always @(negedge i_clk) begin
    if (monitor_on && !i_reset) begin
      if (bus.o_stb || bus.o_err)
        checkOutput("stb_err_excl", {31'd0, bus.o_stb & bus.o_err}, 32'd0);
      if (bus.o_stb) begin
        stb_seen++;
        checkOutput("stb_width", {31'd0, prev_stb}, 32'd0);
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_stb", 32'd1, 32'd0);
        end else begin
          held = exp_q.pop_front();
          checkOutput("word", bus.o_data, held);
        end
      end
      if (bus.o_err) begin
        err_seen++;
        checkOutput("err_width", {31'd0, prev_err}, 32'd0);
        checkOutput("data_hold", bus.o_data, held);
      end
      prev_stb = bus.o_stb;
      prev_err = bus.o_err;
    end
  end

  task automatic idle_bits(input int n);
    bus.i_uart_rx = 1'b1;
    repeat (n * CPB) @(negedge i_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    bus.i_uart_rx = 1'b0;
    repeat (CPB) @(negedge i_clk);
    for (int i = 0; i < 8; i++) begin
      bus.i_uart_rx = b[i];
      repeat (CPB) @(negedge i_clk);
    end
    bus.i_uart_rx = stop_bit;
    repeat (CPB) @(negedge i_clk);
    bus.i_uart_rx = 1'b1;
  endtask

  task automatic send_text(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  // Queues the word a well-formed line should produce, then transmits the line with no inter-byte gap.
  task automatic applyStimulus(input string s, input logic [31:0] expected_word);
    exp_q.push_back(expected_word);
    stbs_expected++;
    send_text(s);
  endtask

  initial begin
    logic [7:0] three;
    i_reset = 1'b1;
    bus.i_uart_rx = 1'b1;
    repeat (4) @(negedge i_clk);
    checkOutput("reset_stb", {31'd0, bus.o_stb}, 32'd0);
    checkOutput("reset_err", {31'd0, bus.o_err}, 32'd0);
    checkOutput("reset_data", bus.o_data, 32'd0);
    i_reset = 1'b0;
    monitor_on = 1'b1;
    idle_bits(2);

    applyStimulus("0x12345678\r\n", 32'h12345678);
    idle_bits(2);
    checkOutput("err_basic", err_seen, errs_expected);

    applyStimulus("0xDEADbeef\r\n", 32'hDEADBEEF);
    applyStimulus("0x00000001\r\n", 32'h00000001);
    idle_bits(2);
    checkOutput("err_b2b", err_seen, errs_expected);

    send_text("0x12G45678\r\n");
    errs_expected++;
    idle_bits(2);
    checkOutput("err_bad_digit", err_seen, errs_expected);
    checkOutput("data_after_bad", bus.o_data, 32'h00000001);
    applyStimulus("0xCAFEF00D\r\n", 32'hCAFEF00D);
    idle_bits(2);

    send_text("0x12");
    send_byte("3", 1'b0);
    errs_expected++;
    idle_bits(3);
    send_text("45678\r\n");
    idle_bits(2);
    checkOutput("err_frame", err_seen, errs_expected);
    applyStimulus("0x00C0FFEE\r\n", 32'h00C0FFEE);
    idle_bits(2);

    bus.i_uart_rx = 1'b0;
    repeat (CPB / 4) @(negedge i_clk);
    bus.i_uart_rx = 1'b1;
    idle_bits(12);
    checkOutput("err_glitch", err_seen, errs_expected);
    applyStimulus("0xA5A5A5A5\r\n", 32'hA5A5A5A5);
    idle_bits(2);

    send_text("0x12");
    three = "3";
    bus.i_uart_rx = 1'b0;
    repeat (CPB) @(negedge i_clk);
    for (int i = 0; i < 3; i++) begin
      bus.i_uart_rx = three[i];
      repeat (CPB) @(negedge i_clk);
    end
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    bus.i_uart_rx = 1'b1;
    held = 32'd0;
    prev_stb = 1'b0;
    prev_err = 1'b0;
    checkOutput("midline_reset_data", bus.o_data, 32'd0);
    idle_bits(12);
    checkOutput("err_after_reset", err_seen, errs_expected);
    applyStimulus("0x0000ABCD\r\n", 32'h0000ABCD);
    idle_bits(2);

    applyStimulus($sformatf("0x%08X\r\n", 32'h89ABCDEF), 32'h89ABCDEF);
    idle_bits(4);

    checkOutput("stb_count", stb_seen, stbs_expected);
    checkOutput("err_count", err_seen, errs_expected);
    checkOutput("queue_empty", exp_q.size(), 32'd0);
    checkOutput("final_data", bus.o_data, 32'h89ABCDEF);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
